// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and helpers for the elevator request path.
//   DEF_N_FLOORS    : default floor count
//   MAX_FLOORS      : widest floor bus the index helper accepts
//   sched_state_e   : scheduler FSM states (IDLE, OFFER, WAIT_ARRIVE)
//   UP / DOWN       : scan direction encodings
//   onehot_to_index : bit position of the (highest) set bit of a floor bus
// ---------------------------------------------------------------------------
package elevator_pkg;

   localparam int DEF_N_FLOORS = 3;
   localparam int MAX_FLOORS   = 32;

   localparam logic UP   = 1'b1;
   localparam logic DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      OFFER       = 2'd1,
      WAIT_ARRIVE = 2'd2
   } sched_state_e;

   // Only meaningful for one-hot input; caller checks one-hotness separately.
   function automatic int onehot_to_index(input logic [MAX_FLOORS-1:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_FLOORS; i++) begin
         if (vec[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/button_sync_edge.sv
// ---------------------------------------------------------------------------
// button_sync_edge
// Synchronizes active-low asynchronous floor buttons and emits a one-cycle
// press pulse on each released->pressed (1->0) transition.
//   clk_i      : system clock
//   reset_i    : synchronous active-high reset (all flops to released)
//   button_n_i : raw active-low buttons
//   press_o    : one-cycle press pulse per floor
// ---------------------------------------------------------------------------
module button_sync_edge #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] button_n_i,
   output logic [WIDTH-1:0] press_o
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_q;

   // Synchronizer chain plus previous-value flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= {WIDTH{1'b1}};
         end
         prev_q <= {WIDTH{1'b1}};
      end else begin
         sync_q[0] <= button_n_i;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Held-low buttons produce a single pulse because prev_q follows the level.
   assign press_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/floor_request_scheduler.sv
// ---------------------------------------------------------------------------
// floor_request_scheduler
// Latches floor-button presses as pending requests and hands one target floor
// at a time to the motion controller using a direction-preserving SCAN policy.
//   clk, reset    : clock, synchronous active-high reset
//   button_n      : raw active-low floor buttons
//   sos_mode      : emergency mode (blocks new requests and offers)
//   current_floor : one-hot cab position
//   moving        : cab in motion
//   arrived       : one-cycle pulse, cab stopped at accepted target
//   led           : pending-request indicators
//   target_floor  : one-hot offered target, stable while target_valid
//   target_valid / target_ready : target handshake
//   direction     : scan direction, 1 = up
// ---------------------------------------------------------------------------
module floor_request_scheduler
   import elevator_pkg::*;
#(
   parameter int N_FLOORS    = DEF_N_FLOORS,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] button_n,
   input  logic                sos_mode,
   input  logic [N_FLOORS-1:0] current_floor,
   input  logic                moving,
   input  logic                arrived,
   output logic [N_FLOORS-1:0] led,
   output logic [N_FLOORS-1:0] target_floor,
   output logic                target_valid,
   input  logic                target_ready,
   output logic                direction
);

   localparam logic [N_FLOORS-1:0] ZERO = {N_FLOORS{1'b0}};
   localparam logic [N_FLOORS-1:0] ONE  = N_FLOORS'(1'b1);

   logic [N_FLOORS-1:0] press_s;
   logic [N_FLOORS-1:0] block_s;
   logic [N_FLOORS-1:0] set_s;
   logic [N_FLOORS-1:0] clr_s;
   logic [N_FLOORS-1:0] pending_d;
   logic [N_FLOORS-1:0] pending_q;
   logic                cf_onehot_s;
   int                  cur_idx_s;
   logic                above_found_s;
   logic                below_found_s;
   int                  above_idx_s;
   int                  below_idx_s;
   logic                sel_found_s;
   logic                sel_dir_s;
   int                  sel_idx_s;
   logic [N_FLOORS-1:0] sel_target_s;
   sched_state_e        state_q;
   logic [N_FLOORS-1:0] target_floor_q;
   logic                target_valid_q;
   logic                direction_q;

   button_sync_edge #(
      .WIDTH       (N_FLOORS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_button_sync_edge (
      .clk_i      (clk),
      .reset_i    (reset),
      .button_n_i (button_n),
      .press_o    (press_s)
   );

   // Next pending set: presses are masked by SOS and by the floor the cab is
   // parked at; an arrival clear overrides a same-cycle press.
   always_comb begin
      cf_onehot_s = $onehot(current_floor);
      cur_idx_s   = onehot_to_index(MAX_FLOORS'(current_floor));
      if (cf_onehot_s && !moving) begin
         block_s = current_floor;
      end else begin
         block_s = ZERO;
      end
      if (sos_mode) begin
         set_s = ZERO;
      end else begin
         set_s = press_s & ~block_s;
      end
      if (arrived) begin
         clr_s = current_floor;
      end else begin
         clr_s = ZERO;
      end
      pending_d = (pending_q | set_s) & ~clr_s;
   end

   // SCAN selector: nearest pending strictly above / below the cab, then pick
   // by current direction, reversing only when nothing lies ahead.
   always_comb begin
      above_found_s = 1'b0;
      below_found_s = 1'b0;
      above_idx_s   = 0;
      below_idx_s   = 0;
      // Descending walk: the last hit is the nearest floor above.
      for (int i = N_FLOORS-1; i >= 0; i--) begin
         if ((i > cur_idx_s) && pending_q[i]) begin
            above_found_s = 1'b1;
            above_idx_s   = i;
         end else begin
            above_found_s = above_found_s;
            above_idx_s   = above_idx_s;
         end
      end
      // Ascending walk: the last hit is the nearest floor below.
      for (int i = 0; i < N_FLOORS; i++) begin
         if ((i < cur_idx_s) && pending_q[i]) begin
            below_found_s = 1'b1;
            below_idx_s   = i;
         end else begin
            below_found_s = below_found_s;
            below_idx_s   = below_idx_s;
         end
      end
      sel_found_s = 1'b0;
      sel_idx_s   = 0;
      sel_dir_s   = direction_q;
      if (direction_q == UP) begin
         if (above_found_s) begin
            sel_found_s = 1'b1;
            sel_idx_s   = above_idx_s;
            sel_dir_s   = UP;
         end else if (below_found_s) begin
            sel_found_s = 1'b1;
            sel_idx_s   = below_idx_s;
            sel_dir_s   = DOWN;
         end else begin
            sel_found_s = 1'b0;
         end
      end else begin
         if (below_found_s) begin
            sel_found_s = 1'b1;
            sel_idx_s   = below_idx_s;
            sel_dir_s   = DOWN;
         end else if (above_found_s) begin
            sel_found_s = 1'b1;
            sel_idx_s   = above_idx_s;
            sel_dir_s   = UP;
         end else begin
            sel_found_s = 1'b0;
         end
      end
      sel_target_s = ONE << sel_idx_s;
   end

   // Pending register and offer/accept/arrive FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q      <= ZERO;
         state_q        <= IDLE;
         target_floor_q <= ZERO;
         target_valid_q <= 1'b0;
         direction_q    <= UP;
      end else begin
         pending_q <= pending_d;
         case (state_q)
            IDLE: begin
               // A pending request at the cab's own floor yields no target.
               if (!sos_mode && cf_onehot_s && sel_found_s) begin
                  target_floor_q <= sel_target_s;
                  target_valid_q <= 1'b1;
                  direction_q    <= sel_dir_s;
                  state_q        <= OFFER;
               end
            end
            OFFER: begin
               // An accepted handshake is final even if SOS rises the same cycle.
               if (target_ready) begin
                  target_valid_q <= 1'b0;
                  state_q        <= WAIT_ARRIVE;
               end else if (sos_mode) begin
                  target_valid_q <= 1'b0;
                  state_q        <= IDLE;
               end
            end
            WAIT_ARRIVE: begin
               if (arrived) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               target_valid_q <= 1'b0;
               state_q        <= IDLE;
            end
         endcase
      end
   end

   assign led          = pending_q;
   assign target_floor = target_floor_q;
   assign target_valid = target_valid_q;
   assign direction    = direction_q;

endmodule

// File: doc/floor_request_scheduler.md
# floor_request_scheduler

Collects passenger floor-button presses, holds them as pending requests, and issues one target floor at a time to the elevator motion controller using a direction-preserving (SCAN) policy. Sits directly upstream of the motion/door controller: it consumes raw active-low buttons plus controller status (current floor, moving, arrived, SOS), and produces the request LEDs and a valid/ready target handshake.

## Interface
Parameters:
- N_FLOORS, 3, number of floors; bit i of every floor bus is floor i+1.
- SYNC_STAGES, 2, synchronizer depth on raw buttons (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- button_n  in  N_FLOORS  raw floor buttons, active-low, asynchronous.
- sos_mode  in  1  emergency mode from controller.
- current_floor  in  N_FLOORS  one-hot floor position from controller.
- moving  in  1  cab in motion.
- arrived  in  1  one-cycle pulse: controller stopped at accepted target, door opening.
- led  out  N_FLOORS  pending-request indicators (registered).
- target_floor  out  N_FLOORS  one-hot target; stable while target_valid.
- target_valid  out  1  target offered.
- target_ready  in  1  controller accepts target.
- direction  out  1  scan direction, 1 = up.

## Operation
- Reset values: led 0, pending 0, target_floor 0, target_valid 0, direction 1, state IDLE; synchronizer and previous-value flops all 1s (released).
- Press = 1→0 transition on synchronized button bit. Held-low button generates exactly one press.
- Press sets pending[i], except: ignored while sos_mode=1; ignored if floor i == current_floor and moving=0.
- arrived clears pending for current_floor bit; on simultaneous press and clear of same floor, clear wins.
- led = pending.
- FSM:
  - IDLE: if pending≠0, sos_mode=0, current_floor one-hot → compute target, drive target_valid=1, go OFFER. Otherwise stay.
  - OFFER: target_floor frozen; new presses do not retarget. target_ready=1 → target_valid=0, go WAIT_ARRIVE. sos_mode=1 → withdraw target_valid, go IDLE (only allowed withdrawal).
  - WAIT_ARRIVE: on arrived → clear pending, go IDLE. sos_mode does not abort.
- SCAN selection from current index c: if direction up and any pending above c → nearest above; else if any pending below c → nearest below, direction←0; else nearest above, direction←1. Mirror for direction down. Pending at c itself never chosen.
- current_floor zero or multi-hot → no target issued; pending still latched.

## Timing
- Button first sampled low at edge k → led high from edge k+SYNC_STAGES.
- led set at edge j with FSM IDLE → target_valid high from edge j+1.
- target_valid & target_ready at edge t → target_valid low from t.
- arrived at edge m → led bit clear and IDLE from m; next target_valid earliest at m+1.
- Button low shorter than one clk period may be missed (by design).
- Reset mid-operation clears everything within the same edge; an in-flight target is dropped without arrived.

## Structure
- Shared package elevator_pkg: N_FLOORS default, FSM state enum (IDLE, OFFER, WAIT_ARRIVE), onehot_to_index function, direction constants UP/DOWN.
- Sub-module button_sync_edge: SYNC_STAGES synchronizer plus falling-edge detector, N_FLOORS wide, outputs one-cycle press pulse vector.
- Top holds pending register, SCAN selector (combinational), FSM.

## Test plan
- Reset, all buttons released, current_floor=001 → led=000, target_valid=0, direction=1 for 20 cycles.
- current_floor=001, press floor 3 → led=100 after 2 cycles, target_valid=1, target_floor=100 next cycle; ready → valid drops; arrived with current_floor=100 → led=000.
- current_floor=010, direction=1, pending floors 1 and 3 → target_floor=100, direction stays 1; after arrival at 3, next target 001, direction=0.
- sos_mode=1 during OFFER → target_valid=0 next edge; press floor 1 during SOS → led unchanged; SOS cleared → target re-offered.
- current_floor=001, moving=0, press floor 1 → led stays 000; press floor 2 held low 50 cycles → exactly one request, led=010.
- Reset asserted in WAIT_ARRIVE with led=110 → led=000, target_valid=0, direction=1 at next edge.
